// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the port arbiter.
// slave = arbiter side, master = stages + memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_wr;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_wr, dm_byte,
    input  dm_addr, dm_wdata,
    input  mem_rdata,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata,
    output mem_en, mem_wr, mem_be,
    output mem_addr, mem_wdata,
    output stall
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_wr, dm_byte,
    output dm_addr, dm_wdata,
    output mem_rdata,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata,
    input  mem_en, mem_wr, mem_be,
    input  mem_addr, mem_wdata,
    input  stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data.
// Define ARB_STATS_EN to add if_cnt/dm_cnt/stall_cnt counters.
module mem_port_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ARB_STATS_EN
  output logic [15:0] if_cnt,
  output logic [15:0] dm_cnt,
  output logic [15:0] stall_cnt,
`endif
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] RUN_MAX  = 4'(MAX_DATA_RUN);
  localparam logic [3:0] WAIT_END = 4'(MEM_LAT - 2);
  localparam bit         NO_WAIT  = (MEM_LAT == 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  wcnt;
  logic [3:0]  run;
  logic        kill;
  logic        g_if;
  logic        g_wr;
  logic        g_byte;
  logic [1:0]  g_off;
  logic [29:0] g_word;
  logic [3:0]  g_be;
  logic [31:0] g_wdata;
  logic [31:0] if_q;
  logic [31:0] dm_q;
  logic [31:0] ld_data;
  logic        if_pend;
  logic        pick_if;
  logic        pick_dm;
  logic        done;
  logic        if_ack;
  logic        dm_ack;
  logic        issue;
  logic        stall;

  assign if_pend = bus.if_req & ~bus.if_flush;

  // fetch beats data only when data is idle or the data run hit its cap
  always_comb begin
    pick_if = 1'b0;
    pick_dm = 1'b0;
    if (state == IDLE) begin
      if (if_pend && (run == RUN_MAX || !bus.dm_req))
        pick_if = 1'b1;
      else if (bus.dm_req)
        pick_dm = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (pick_if || pick_dm)
          state_nx = ISSUE;
      ISSUE:
        state_nx = NO_WAIT ? DONE : WAIT;
      WAIT:
        if (wcnt == WAIT_END)
          state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      run     <= '0;
      kill    <= 1'b0;
      g_if    <= 1'b0;
      g_wr    <= 1'b0;
      g_byte  <= 1'b0;
      g_off   <= '0;
      g_word  <= '0;
      g_be    <= '0;
      g_wdata <= '0;
      if_q    <= '0;
      dm_q    <= '0;
    end else begin
      wcnt <= (state == WAIT) ? wcnt + 4'd1 : 4'd0;
      if (state == IDLE) begin
        if (pick_if || !bus.if_req)
          run <= '0;
        else if (pick_dm && run != RUN_MAX)
          run <= run + 4'd1;
      end
      if (pick_if) begin
        g_if    <= 1'b1;
        g_wr    <= 1'b0;
        g_byte  <= 1'b0;
        g_off   <= '0;
        g_word  <= bus.if_addr[31:2];
        g_be    <= 4'hF;
        g_wdata <= '0;
        kill    <= 1'b0;
      end else if (pick_dm) begin
        g_if    <= 1'b0;
        g_wr    <= bus.dm_wr;
        g_byte  <= bus.dm_byte;
        g_off   <= bus.dm_addr[1:0];
        g_word  <= bus.dm_addr[31:2];
        g_be    <= bus.dm_byte ?
                   4'b0001 << bus.dm_addr[1:0] :
                   4'hF;
        g_wdata <= bus.dm_byte ?
                   {4{bus.dm_wdata[7:0]}} :
                   bus.dm_wdata;
        kill    <= 1'b0;
      end else if (state != IDLE && g_if && bus.if_flush) begin
        kill <= 1'b1;
      end
      if (if_ack)
        if_q <= bus.mem_rdata;
      if (dm_ack)
        dm_q <= ld_data;
    end
  end

  always_comb begin
    issue   = (state == ISSUE);
    done    = (state == DONE) & ~rst;
    if_ack  = done & g_if & ~kill & ~bus.if_flush;
    dm_ack  = done & ~g_if;
    ld_data = bus.mem_rdata;
    if (g_byte)
      ld_data = {24'h0, bus.mem_rdata[{g_off, 3'b000} +: 8]};
    stall = (bus.if_req & ~if_ack & ~bus.if_flush) |
            (bus.dm_req & ~dm_ack);
  end

  assign bus.if_ack    = if_ack;
  assign bus.dm_ack    = dm_ack;
  assign bus.if_rdata  = if_ack ? bus.mem_rdata : if_q;
  assign bus.dm_rdata  = dm_ack ? ld_data : dm_q;
  assign bus.mem_en    = issue;
  assign bus.mem_wr    = issue & g_wr;
  assign bus.mem_be    = g_be;
  assign bus.mem_addr  = {g_word, 2'b00};
  assign bus.mem_wdata = g_wdata;
  assign bus.stall     = stall;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_cnt    <= '0;
      dm_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (if_ack)
        if_cnt <= if_cnt + 16'd1;
      if (dm_ack)
        dm_cnt <= dm_cnt + 16'd1;
      if (stall)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cases plus random traffic against a
// transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

`ifdef ARB_STATS_EN
  logic [15:0] if_cnt;
  logic [15:0] dm_cnt;
  logic [15:0] stall_cnt;
`endif

  mem_port_arbiter #(
    .MEM_LAT(2),
    .MAX_DATA_RUN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef ARB_STATS_EN
    .if_cnt(if_cnt),
    .dm_cnt(dm_cnt),
    .stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );

  function automatic logic [31:0] f_init(int i);
    if (i == 64)
      return 32'hE3A01005;
    if (i == 128)
      return 32'h11223344;
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // memory with two cycles of read latency
  logic [31:0] mem [256];
  logic [31:0] p0;
  logic [31:0] p1;
  int          n_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= f_init(i);
    end else if (bus.mem_en) begin
      p0 <= mem[bus.mem_addr[9:2]];
      n_en <= n_en + 1;
      if (bus.mem_wr)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b])
            mem[bus.mem_addr[9:2]][8*b +: 8] <=
              bus.mem_wdata[8*b +: 8];
    end
    p1 <= p0;
  end

  assign bus.mem_rdata = p1;

  logic [15:0] m_if;
  logic [15:0] m_dm;
  logic [15:0] m_st;

  always @(posedge clk) begin
    if (rst) begin
      m_if <= '0;
      m_dm <= '0;
      m_st <= '0;
    end else begin
      if (bus.if_ack) m_if <= m_if + 16'd1;
      if (bus.dm_ack) m_dm <= m_dm + 16'd1;
      if (bus.stall)  m_st <= m_st + 16'd1;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_byte  = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
  endtask

  task automatic dm_go(input logic wr, input logic by,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [3:0] be,
                       output logic [31:0] mw, output int lat);
    step();
    bus.dm_req   = 1'b1;
    bus.dm_wr    = wr;
    bus.dm_byte  = by;
    bus.dm_addr  = a;
    bus.dm_wdata = wd;
    lat = -1;
    rd  = '0;
    be  = '0;
    mw  = '0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      step();
      if (bus.mem_en) begin
        be = bus.mem_be;
        mw = bus.mem_wdata;
      end
      if (bus.dm_ack) begin
        lat = k;
        rd  = bus.dm_rdata;
      end
    end
    bus.dm_req = 1'b0;
  endtask

  function automatic logic [31:0] exp_ld(logic [31:0] w, logic by,
                                         logic [1:0] off);
    if (by)
      return {24'h0, w[8*off +: 8]};
    return w;
  endfunction

  logic [31:0] refm [256];
  logic [31:0] rd;
  logic [3:0]  be;
  logic [31:0] mw;
  int          lat;
  int          n0;
  int          ord [$];
  int          exp_ord [7];
  int          rem;
  int          f_on, f_wait, d_on, d_wait, last_en;
  logic        d_wr, d_by;
  logic [31:0] d_addr, d_wd;
  localparam int FW = 26;
  localparam int DW = 12;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst if_ack", bus.if_ack, 0);
    chk("rst dm_ack", bus.dm_ack, 0);
    chk("rst mem_en", bus.mem_en, 0);
    chk("rst mem_wr", bus.mem_wr, 0);
    chk("rst mem_be", bus.mem_be, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst if_rdata", bus.if_rdata, 0);
    chk("rst dm_rdata", bus.dm_rdata, 0);
    chk("rst stall", bus.stall, 0);

    // 1: lone fetch
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    chk("t1 stall c0", bus.stall, 1);
    chk("t1 en c0", bus.mem_en, 0);
    step();
    chk("t1 en c1", bus.mem_en, 1);
    chk("t1 addr c1", bus.mem_addr, 32'h100);
    chk("t1 be c1", bus.mem_be, 4'hF);
    chk("t1 wr c1", bus.mem_wr, 0);
    step();
    chk("t1 ack c2", bus.if_ack, 0);
    chk("t1 stall c2", bus.stall, 1);
    step();
    chk("t1 ack c3", bus.if_ack, 1);
    chk("t1 rdata c3", bus.if_rdata, 32'hE3A01005);
    chk("t1 stall c3", bus.stall, 0);
    bus.if_req = 1'b0;
    step();
    chk("t1 ack c4", bus.if_ack, 0);
    chk("t1 hold c4", bus.if_rdata, 32'hE3A01005);

    // 2: simultaneous fetch and load
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.dm_req  = 1'b1;
    bus.dm_wr   = 1'b0;
    bus.dm_byte = 1'b0;
    bus.dm_addr = 32'h200;
    step();
    chk("t2 en c1", bus.mem_en, 1);
    chk("t2 addr c1", bus.mem_addr, 32'h200);
    step();
    step();
    chk("t2 dack c3", bus.dm_ack, 1);
    chk("t2 drd c3", bus.dm_rdata, 32'h11223344);
    chk("t2 iack c3", bus.if_ack, 0);
    chk("t2 stall c3", bus.stall, 1);
    bus.dm_req = 1'b0;
    step();
    chk("t2 en c4", bus.mem_en, 0);
    step();
    chk("t2 en c5", bus.mem_en, 1);
    chk("t2 addr c5", bus.mem_addr, 32'h100);
    step();
    chk("t2 iack c6", bus.if_ack, 0);
    step();
    chk("t2 iack c7", bus.if_ack, 1);
    chk("t2 ird c7", bus.if_rdata, 32'hE3A01005);
    bus.if_req = 1'b0;
    step();

    // 3: byte lanes
    dm_go(1'b0, 1'b1, 32'h201, 32'h0, rd, be, mw, lat);
    chk("t3 ldrb lat", lat, 3);
    chk("t3 ldrb be", be, 4'b0010);
    chk("t3 ldrb rd", rd, 32'h33);
    dm_go(1'b1, 1'b1, 32'h203, 32'hAB, rd, be, mw, lat);
    chk("t3 strb lat", lat, 3);
    chk("t3 strb be", be, 4'b1000);
    chk("t3 strb wd", mw, 32'hABABABAB);
    dm_go(1'b0, 1'b1, 32'h203, 32'h0, rd, be, mw, lat);
    chk("t3 ldrb3 rd", rd, 32'hAB);
    dm_go(1'b1, 1'b0, 32'h208, 32'hCAFEBABE, rd, be, mw, lat);
    chk("t3 str be", be, 4'hF);
    chk("t3 str wd", mw, 32'hCAFEBABE);
    dm_go(1'b0, 1'b0, 32'h208, 32'h0, rd, be, mw, lat);
    chk("t3 ldr rd", rd, 32'hCAFEBABE);
    step();
    chk("t3 mem word", mem[128], 32'hAB223344);

    // 4: starvation guard
    exp_ord = '{0, 0, 0, 0, 1, 0, 0};
    ord.delete();
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10C;
    bus.dm_req  = 1'b1;
    bus.dm_wr   = 1'b0;
    bus.dm_byte = 1'b0;
    bus.dm_addr = 32'h204;
    rem = 6;
    for (int k = 0; k < 80 && (rem > 0 || bus.if_req); k++) begin
      step();
      if (bus.dm_ack) begin
        ord.push_back(0);
        rem--;
        if (rem == 0) bus.dm_req = 1'b0;
      end
      if (bus.if_ack) begin
        ord.push_back(1);
        bus.if_req = 1'b0;
      end
    end
    chk("t4 grants", ord.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t4 ord%0d", i),
          ord.size() > i ? ord[i] : 9, exp_ord[i]);
    step();

    // 5: flush during fetch
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    n0 = n_en;
    step();
    step();
    bus.if_flush = 1'b1;
    bus.if_req   = 1'b0;
    #1;
    chk("t5 ack c2", bus.if_ack, 0);
    chk("t5 stall c2", bus.stall, 0);
    step();
    bus.if_flush = 1'b0;
    #1;
    chk("t5 ack c3", bus.if_ack, 0);
    step();
    chk("t5 ack c4", bus.if_ack, 0);
    bus.dm_req  = 1'b1;
    bus.dm_wr   = 1'b0;
    bus.dm_byte = 1'b0;
    bus.dm_addr = 32'h200;
    step();
    chk("t5 idle c4", bus.mem_en, 1);
    chk("t5 one en", n_en - n0, 1);
    step();
    step();
    chk("t5 dack", bus.dm_ack, 1);
    chk("t5 drd", bus.dm_rdata, 32'hAB223344);
    bus.dm_req = 1'b0;
    step();

    // 6: reset mid-load
    step();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h208;
    step();
    step();
    rst = 1'b1;
    step();
    chk("t6 dack c3", bus.dm_ack, 0);
    chk("t6 en c3", bus.mem_en, 0);
    chk("t6 drd c3", bus.dm_rdata, 0);
    chk("t6 ird c3", bus.if_rdata, 0);
    chk("t6 be c3", bus.mem_be, 0);
    chk("t6 addr c3", bus.mem_addr, 0);
    chk("t6 wd c3", bus.mem_wdata, 0);
`ifdef ARB_STATS_EN
    chk("t6 if_cnt", if_cnt, 0);
    chk("t6 dm_cnt", dm_cnt, 0);
    chk("t6 st_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    bus.dm_req = 1'b0;
    step();
    chk("t6 dack c4", bus.dm_ack, 0);
    chk("t6 en c4", bus.mem_en, 0);

    // random traffic
    for (int i = 0; i < 256; i++)
      refm[i] = f_init(i);
    f_on = 0;
    d_on = 0;
    f_wait = 0;
    d_wait = 0;
    last_en = -100;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (f_on != 0) f_wait++;
      if (d_on != 0) d_wait++;
      chk("r stall", bus.stall,
          (bus.if_req & ~bus.if_ack & ~bus.if_flush) |
          (bus.dm_req & ~bus.dm_ack));
      chk("r two acks", bus.if_ack & bus.dm_ack, 0);
      if (bus.mem_en) begin
        chk("r spacing", (c - last_en) >= 4, 1);
        chk("r align", bus.mem_addr[1:0], 0);
        last_en = c;
      end
      if (bus.if_ack) begin
        chk("r if live", f_on, 1);
        if (f_on != 0) begin
          chk("r if data", bus.if_rdata,
              refm[bus.if_addr[9:2]]);
          chk("r if wait", f_wait <= FW, 1);
        end
        f_on = 0;
      end
      if (bus.dm_ack) begin
        chk("r dm live", d_on, 1);
        if (d_on != 0) begin
          chk("r dm wait", d_wait <= DW, 1);
          if (d_wr) begin
            if (d_by)
              refm[d_addr[9:2]][8*d_addr[1:0] +: 8] = d_wd[7:0];
            else
              refm[d_addr[9:2]] = d_wd;
          end else begin
            chk("r dm data", bus.dm_rdata,
                exp_ld(refm[d_addr[9:2]], d_by, d_addr[1:0]));
          end
        end
        d_on = 0;
      end
      if (bus.if_flush) begin
        bus.if_flush = 1'b0;
      end else if (f_on != 0 && $urandom_range(0, 19) == 0) begin
        bus.if_flush = 1'b1;
        f_on = 0;
      end else if (f_on == 0 && $urandom_range(0, 3) == 0) begin
        f_on = 1;
        f_wait = 0;
        bus.if_addr = 32'h200 + ($urandom_range(0, 15) << 2);
      end
      if (d_on == 0 && $urandom_range(0, 2) == 0) begin
        d_on   = 1;
        d_wait = 0;
        d_wr   = 1'($urandom_range(0, 1));
        d_by   = 1'($urandom_range(0, 1));
        d_wd   = $urandom;
        d_addr = 32'h200 + ($urandom_range(0, 15) << 2);
        if (d_by)
          d_addr = d_addr + $urandom_range(0, 3);
        bus.dm_wr    = d_wr;
        bus.dm_byte  = d_by;
        bus.dm_addr  = d_addr;
        bus.dm_wdata = d_wd;
      end
      bus.if_req = (f_on != 0);
      bus.dm_req = (d_on != 0);
    end
    if (f_on != 0) chk("r if pend", f_wait <= FW, 1);
    if (d_on != 0) chk("r dm pend", d_wait <= DW, 1);
`ifdef ARB_STATS_EN
    chk("r if_cnt", if_cnt, m_if);
    chk("r dm_cnt", dm_cnt, m_dm);
    chk("r st_cnt", stall_cnt, m_st);
`endif
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
